// File: rtl/booth_digit_seq_pkg.sv
// Shared definitions for the sequential radix-4 Booth recoder: default sizes,
// control state encoding and the Booth triplet codes.
package booth_digit_seq_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int NDIG_DEF  = WIDTH_DEF / 2;
  localparam int IDXW_DEF  = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Triplet {y[2i+1], y[2i], y[2i-1]} and the multiple it selects
  localparam logic [2:0] BD_ZERO_A = 3'b000;
  localparam logic [2:0] BD_P1_A   = 3'b001;
  localparam logic [2:0] BD_P1_B   = 3'b010;
  localparam logic [2:0] BD_P2     = 3'b011;
  localparam logic [2:0] BD_M2     = 3'b100;
  localparam logic [2:0] BD_M1_A   = 3'b101;
  localparam logic [2:0] BD_M1_B   = 3'b110;
  localparam logic [2:0] BD_ZERO_B = 3'b111;

endpackage

// File: rtl/booth_digit_seq_tri.sv
// Booth triplet extraction: the two low operand bits plus the guard bit
// that holds the previous pair's upper bit.
module booth_tri_extract (
  input  logic [1:0] sr_lo_i,
  input  logic       g_i,
  output logic [2:0] dig_y_o
);

  assign dig_y_o = {sr_lo_i, g_i};

endmodule

// File: rtl/booth_digit_seq.sv
// Sequential radix-4 Booth recoder: takes one multiplier operand per
// handshake and streams one triplet per accepted cycle, LSB digit first.
module booth_digit_seq
  import booth_digit_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NDIG  = WIDTH / 2,
  parameter int IDXW  = IDXW_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [WIDTH-1:0] op_y,
  input  logic             op_msub,
  input  logic             op_signed,
  output logic             dig_valid,
  input  logic             dig_ready,
  output logic [2:0]       dig_y,
  output logic             dig_msub,
  output logic [IDXW-1:0]  dig_idx,
  output logic             dig_first,
  output logic             dig_last,
  output logic             busy
);

  state_e            state_q, state_d;
  logic [WIDTH+1:0]  sr_q, sr_d;
  logic              g_q, g_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [IDXW-1:0]   lidx_q, lidx_d;
  logic              msub_q, msub_d;
  logic              valid_q, valid_d;
  logic [2:0]        y_q, y_d;
  logic              first_q, first_d;
  logic              lastf_q, lastf_d;
  logic              accept_s;
  logic              load_s;
  logic [2:0]        tri_s;

  assign accept_s = valid_q && dig_ready;
  assign op_ready = !flush && ((state_q == ST_IDLE) || (accept_s && lastf_q));
  assign load_s   = op_valid && op_ready;

  // Control and operand next state: flush > load > advance > hold
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    g_d     = g_q;
    idx_d   = idx_q;
    lidx_d  = lidx_q;
    msub_d  = msub_q;
    valid_d = valid_q;
    if (flush) begin
      state_d = ST_IDLE;
      sr_d    = '0;
      g_d     = 1'b0;
      idx_d   = '0;
      msub_d  = 1'b0;
      valid_d = 1'b0;
    end else if (load_s) begin
      state_d = ST_RUN;
      sr_d    = op_signed ? {{2{op_y[WIDTH-1]}}, op_y} : {2'b00, op_y};
      g_d     = 1'b0;
      idx_d   = '0;
      lidx_d  = op_signed ? IDXW'(NDIG - 1) : IDXW'(NDIG);
      msub_d  = op_msub;
      valid_d = 1'b1;
    end else if (accept_s) begin
      if (lastf_q) begin
        state_d = ST_IDLE;
        sr_d    = '0;
        g_d     = 1'b0;
        idx_d   = '0;
        msub_d  = 1'b0;
        valid_d = 1'b0;
      end else begin
        sr_d  = {{2{sr_q[WIDTH+1]}}, sr_q[WIDTH+1:2]};
        g_d   = sr_q[1];
        idx_d = idx_q + IDXW'(1);
      end
    end else begin
      state_d = state_q;
    end
  end

  booth_tri_extract u_tri (
    .sr_lo_i (sr_d[1:0]),
    .g_i     (g_d),
    .dig_y_o (tri_s)
  );

  // Digit presentation derived from the next operand state
  always_comb begin
    y_d     = valid_d ? tri_s : 3'b000;
    first_d = valid_d && (idx_d == '0);
    lastf_d = valid_d && (idx_d == lidx_d);
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      g_q     <= 1'b0;
      idx_q   <= '0;
      lidx_q  <= '0;
      msub_q  <= 1'b0;
      valid_q <= 1'b0;
      y_q     <= 3'b000;
      first_q <= 1'b0;
      lastf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      g_q     <= g_d;
      idx_q   <= idx_d;
      lidx_q  <= lidx_d;
      msub_q  <= msub_d;
      valid_q <= valid_d;
      y_q     <= y_d;
      first_q <= first_d;
      lastf_q <= lastf_d;
    end
  end

  assign dig_valid = valid_q;
  assign dig_y     = y_q;
  assign dig_msub  = msub_q;
  assign dig_idx   = idx_q;
  assign dig_first = first_q;
  assign dig_last  = lastf_q;
  assign busy      = (state_q == ST_RUN);

endmodule

// File: tb/tb_booth_digit_seq.sv
// Directed bench for booth_digit_seq: hand-computed digit streams, back-to-back
// handshake under random backpressure, flush and asynchronous reset.
module tb_booth_digit_seq;
  import booth_digit_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, op_valid, op_ready, op_msub, op_signed;
  logic [15:0] op_y;
  logic        dig_valid, dig_ready, dig_msub, dig_first, dig_last, busy;
  logic [2:0]  dig_y;
  logic [3:0]  dig_idx;

  int n_total = 0;
  int n_bad   = 0;

  booth_digit_seq dut (
    .clk(clk), .rst(rst), .flush(flush), .op_valid(op_valid), .op_ready(op_ready),
    .op_y(op_y), .op_msub(op_msub), .op_signed(op_signed), .dig_valid(dig_valid),
    .dig_ready(dig_ready), .dig_y(dig_y), .dig_msub(dig_msub), .dig_idx(dig_idx),
    .dig_first(dig_first), .dig_last(dig_last), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int bval(input logic [2:0] t);
    case (t)
      BD_P1_A, BD_P1_B: return 1;
      BD_P2:            return 2;
      BD_M2:            return -2;
      BD_M1_A, BD_M1_B: return -1;
      default:          return 0;
    endcase
  endfunction

  function automatic logic [2:0] exp_trip(input logic [15:0] y, input logic sgn, input int i);
    logic [17:0] e;
    logic [18:0] x;
    e = sgn ? {{2{y[15]}}, y} : {2'b00, y};
    x = {e, 1'b0};
    return x[2*i+2 -: 3];
  endfunction

  // One operand with dig_ready held high; d0/dl/expv are hand-computed
  task automatic run_op(input logic [15:0] y, input logic sgn, input logic ms, input int n,
                        input logic [2:0] d0, input logic [2:0] dl, input int expv, input string tag);
    int sum;
    sum = 0;
    @(negedge clk);
    check_eq({tag, "_ready"}, 32'(op_ready), 32'd1);
    op_valid = 1'b1; op_y = y; op_signed = sgn; op_msub = ms; dig_ready = 1'b1;
    @(negedge clk);
    op_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      check_eq({tag, "_valid"}, 32'(dig_valid), 32'd1);
      check_eq({tag, "_idx"},   32'(dig_idx),   32'(i));
      check_eq({tag, "_first"}, 32'(dig_first), 32'(i == 0));
      check_eq({tag, "_last"},  32'(dig_last),  32'(i == n - 1));
      check_eq({tag, "_msub"},  32'(dig_msub),  32'(ms));
      check_eq({tag, "_y"},     32'(dig_y),     32'(exp_trip(y, sgn, i)));
      if (i == 0)     check_eq({tag, "_d0"},   32'(dig_y), 32'(d0));
      if (i == n - 1) check_eq({tag, "_dlast"}, 32'(dig_y), 32'(dl));
      sum += bval(dig_y) * (1 << (2 * i));
      @(negedge clk);
    end
    check_eq({tag, "_idle"}, 32'(dig_valid), 32'd0);
    check_eq({tag, "_sum"},  32'(sum), 32'(expv));
  endtask

  logic [15:0] b_y [4]   = '{16'h1234, 16'hBEEF, 16'h7FFF, 16'h0001};
  logic        b_s [4]   = '{1'b1, 1'b0, 1'b1, 1'b0};
  logic        b_m [4]   = '{1'b0, 1'b1, 1'b0, 1'b1};
  logic [2:0]  e_y [64];
  logic        e_m [64];
  int          e_i [64];
  logic        e_l [64];

  initial begin
    int n_exp, op_ptr, exp_ptr, cyc, n, guard;
    logic started, stall_prev;
    logic [10:0] saved;

    rst = 1'b1; flush = 1'b0; op_valid = 1'b0; op_y = 16'h0; op_msub = 1'b0;
    op_signed = 1'b0; dig_ready = 1'b0;
    #12;
    check_eq("rst_valid", 32'(dig_valid), 32'd0);
    check_eq("rst_outs", 32'({dig_y, dig_msub, dig_idx, dig_first, dig_last}), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    #1;
    check_eq("rst_ready", 32'(op_ready), 32'd1);

    run_op(16'h0003, 1'b1, 1'b0, 8, 3'b110, 3'b000, 3, "s3");
    run_op(16'h8000, 1'b1, 1'b1, 8, 3'b000, 3'b100, -32768, "s8000");
    run_op(16'hFFFF, 1'b0, 1'b0, 9, 3'b110, 3'b001, 65535, "uffff");

    // Back-to-back operands under random backpressure
    n_exp = 0;
    for (int k = 0; k < 4; k++) begin
      n = b_s[k] ? 8 : 9;
      for (int i = 0; i < n; i++) begin
        e_y[n_exp] = exp_trip(b_y[k], b_s[k], i);
        e_m[n_exp] = b_m[k];
        e_i[n_exp] = i;
        e_l[n_exp] = (i == n - 1);
        n_exp++;
      end
    end
    op_ptr = 0; exp_ptr = 0; cyc = 0; started = 1'b0; stall_prev = 1'b0; saved = '0;
    while (exp_ptr < n_exp && cyc < 500) begin
      @(negedge clk);
      cyc++;
      if (stall_prev)
        check_eq("b2b_stall", 32'({dig_y, dig_msub, dig_idx, dig_first, dig_last, dig_valid}), 32'(saved));
      if (started) check_eq("b2b_nogap", 32'(dig_valid), 32'd1);
      dig_ready = 1'($urandom_range(0, 1));
      if (dig_valid && dig_ready) begin
        check_eq("b2b_y",    32'(dig_y),    32'(e_y[exp_ptr]));
        check_eq("b2b_msub", 32'(dig_msub), 32'(e_m[exp_ptr]));
        check_eq("b2b_idx",  32'(dig_idx),  32'(e_i[exp_ptr]));
        check_eq("b2b_last", 32'(dig_last), 32'(e_l[exp_ptr]));
        exp_ptr++;
      end
      saved = {dig_y, dig_msub, dig_idx, dig_first, dig_last, dig_valid};
      stall_prev = dig_valid && !dig_ready;
      op_valid = (op_ptr < 4);
      if (op_ptr < 4) begin
        op_y = b_y[op_ptr]; op_signed = b_s[op_ptr]; op_msub = b_m[op_ptr];
      end
      #1;
      if (op_valid && op_ready) begin
        op_ptr++;
        started = 1'b1;
      end
      if (exp_ptr >= n_exp) started = 1'b0;
    end
    check_eq("b2b_done", 32'(exp_ptr), 32'(n_exp));
    @(negedge clk);
    op_valid = 1'b0; dig_ready = 1'b1;
    guard = 0;
    while (dig_valid && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check_eq("b2b_drain", 32'(dig_valid), 32'd0);

    // Flush at digit 3 with a new operand offered
    op_valid = 1'b1; op_y = 16'h5555; op_signed = 1'b1; op_msub = 1'b0;
    @(negedge clk);
    op_valid = 1'b0;
    guard = 0;
    while (dig_idx != 4'd3 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check_eq("fl_at3", 32'(dig_idx), 32'd3);
    flush = 1'b1; op_valid = 1'b1; op_y = 16'h0003; op_signed = 1'b1; op_msub = 1'b1;
    #1;
    check_eq("fl_ready_low", 32'(op_ready), 32'd0);
    @(negedge clk);
    check_eq("fl_valid", 32'(dig_valid), 32'd0);
    check_eq("fl_busy", 32'(busy), 32'd0);
    #1;
    check_eq("fl_ready_held", 32'(op_ready), 32'd0);
    flush = 1'b0;
    #1;
    check_eq("fl_ready_after", 32'(op_ready), 32'd1);
    @(negedge clk);
    op_valid = 1'b0;
    check_eq("fl_new_valid", 32'(dig_valid), 32'd1);
    check_eq("fl_new_idx", 32'(dig_idx), 32'd0);
    check_eq("fl_new_y", 32'(dig_y), 32'b110);
    check_eq("fl_new_msub", 32'(dig_msub), 32'd1);
    guard = 0;
    while (dig_valid && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check_eq("fl_drain", 32'(dig_valid), 32'd0);

    // Asynchronous reset in the middle of an operand
    op_valid = 1'b1; op_y = 16'hFFFF; op_signed = 1'b0; op_msub = 1'b1;
    @(negedge clk);
    op_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("ar_pre_idx", 32'(dig_idx), 32'd2);
    #2;
    rst = 1'b1;
    #1;
    check_eq("ar_valid", 32'(dig_valid), 32'd0);
    check_eq("ar_outs", 32'({dig_y, dig_msub, dig_idx, dig_first, dig_last}), 32'd0);
    check_eq("ar_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    #1;
    check_eq("ar_ready", 32'(op_ready), 32'd1);
    @(negedge clk);
    check_eq("ar_no_partial", 32'(dig_valid), 32'd0);
    op_valid = 1'b1; op_y = 16'h0003; op_signed = 1'b1; op_msub = 1'b0;
    @(negedge clk);
    op_valid = 1'b0;
    check_eq("ar_new_valid", 32'(dig_valid), 32'd1);
    check_eq("ar_new_idx", 32'(dig_idx), 32'd0);
    check_eq("ar_new_first", 32'(dig_first), 32'd1);
    check_eq("ar_new_y", 32'(dig_y), 32'b110);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
